// File: rtl/disp_scan_if.sv
// rtl/disp_scan_if.sv - segment inputs and multiplexed display outputs of the scanner
interface disp_scan_if;
  logic [6:0] SEG0;
  logic [6:0] SEG1;
  logic [6:0] SEG2;
  logic [6:0] SEG3;
  logic [3:0] BLINK_MASK;
  logic [6:0] SEG_OUT;
  logic [3:0] AN;
  logic [1:0] DIG_IDX;

  // Source of digit data and sink of the display drive
  modport master (
    output SEG0, SEG1, SEG2, SEG3, BLINK_MASK,
    input  SEG_OUT, AN, DIG_IDX
  );

  // The scanner itself
  modport slave (
    input  SEG0, SEG1, SEG2, SEG3, BLINK_MASK,
    output SEG_OUT, AN, DIG_IDX
  );
endinterface

// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - 4-digit 7-segment scanner with dead time and blink; DISP_SCAN_LZB_EN enables leading-zero blanking
module disp_scan #(
  parameter int DIV       = 1024,
  parameter int BLANK_CYC = 2,
  parameter int BLINK_LEN = 128
) (
  input  logic        CLK,
  input  logic        RST_N,
  disp_scan_if.slave  bus
);

  localparam logic [15:0] DIV_M1   = 16'(DIV - 1);
  localparam logic [15:0] BLANK_M1 = 16'(BLANK_CYC - 1);
  localparam logic [15:0] BLINK_M1 = 16'(BLINK_LEN - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic [6:0]  sel_seg;

  // State, counters and registered outputs; reset blanks the display without waiting for a clock
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd3;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  // Next state: BLANK dead time advances the digit, end of SHOW bumps the blink counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_M1) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DIV_M1) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (bcnt_q == BLINK_M1) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
          end else begin
            bcnt_d = bcnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Digit data selected by the index the display will show after this edge
  always_comb begin
    sel_seg = 7'b1111111;
    case (idx_d)
      2'd0:    sel_seg = bus.SEG0;
      2'd1:    sel_seg = bus.SEG1;
      2'd2:    sel_seg = bus.SEG2;
      2'd3:    sel_seg = bus.SEG3;
      default: sel_seg = 7'b1111111;
    endcase
  end

  // Output decode from next state so the registered AN/SEG_OUT line up with state_q
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    if (state_d == ST_SHOW) begin
      an_d[idx_d] = 1'b0;
      seg_d       = sel_seg;
      if (phase_d && bus.BLINK_MASK[idx_d]) begin
        seg_d = 7'b1111111;
      end
`ifdef DISP_SCAN_LZB_EN
      // A leading "0" on tens-of-minutes is suppressed; the anode still fires
      if ((idx_d == 2'd3) && (bus.SEG3 == 7'b0000001)) begin
        seg_d = 7'b1111111;
      end
`endif
    end
  end

  assign bus.AN      = an_q;
  assign bus.SEG_OUT = seg_q;
  assign bus.DIG_IDX = idx_q;

endmodule

// File: tb/tb_disp_scan.sv
// tb/tb_disp_scan.sv - directed self-checking bench for disp_scan (DIV=8, BLANK_CYC=2, BLINK_LEN=4)
`timescale 1ns/1ps
module tb_disp_scan;

  localparam int PER = 10;
  localparam int BL  = 2;
  localparam int BLK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] seg_v [4];
  logic [3:0] mask_v;
  int errors = 0;
  int checks = 0;

  disp_scan_if bus ();

  assign bus.SEG0       = seg_v[0];
  assign bus.SEG1       = seg_v[1];
  assign bus.SEG2       = seg_v[2];
  assign bus.SEG3       = seg_v[3];
  assign bus.BLINK_MASK = mask_v;

  disp_scan #(.DIV(8), .BLANK_CYC(2), .BLINK_LEN(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected values k rising edges after reset release
  function automatic logic [3:0] m_an(int k);
    int r, d;
    r = k % PER;
    d = (k / PER) % 4;
    if (r < BL) return 4'b1111;
    return ~(4'b0001 << d);
  endfunction

  function automatic logic [1:0] m_idx(int k);
    int p, r;
    p = k / PER;
    r = k % PER;
    if (r < BL) return 2'((p + 3) % 4);
    return 2'(p % 4);
  endfunction

  function automatic logic [6:0] m_seg(int k);
    int p, r, d;
    p = k / PER;
    r = k % PER;
    d = p % 4;
    if (r < BL) return 7'h7F;
    if (mask_v[d] && (((p / BLK) % 2) == 1)) return 7'h7F;
`ifdef DISP_SCAN_LZB_EN
    if ((d == 3) && (seg_v[3] == 7'h01)) return 7'h7F;
`endif
    return seg_v[d];
  endfunction

  function automatic int zeros4(logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (v[i] == 1'b0) n++;
    return n;
  endfunction

  task automatic hold_reset_release();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.AN !== 4'b1111) begin
      errors++; $display("FAIL reset_an got=%b want=1111", bus.AN);
    end
    checks++;
    if (bus.SEG_OUT !== 7'h7F) begin
      errors++; $display("FAIL reset_seg got=%h want=7f", bus.SEG_OUT);
    end
    checks++;
    if (bus.DIG_IDX !== 2'd3) begin
      errors++; $display("FAIL reset_idx got=%0d want=3", bus.DIG_IDX);
    end
  endtask

  task automatic test_scan();
    seg_v[0] = 7'h01; seg_v[1] = 7'h4F; seg_v[2] = 7'h12; seg_v[3] = 7'h06;
    mask_v = 4'b0000;
    hold_reset_release();
    for (int k = 0; k < 10 * 4 * PER; k++) begin
      checks++;
      if (bus.AN !== m_an(k)) begin
        errors++; $display("FAIL scan_an k=%0d got=%b want=%b", k, bus.AN, m_an(k));
      end
      checks++;
      if (bus.DIG_IDX !== m_idx(k)) begin
        errors++; $display("FAIL scan_idx k=%0d got=%0d want=%0d", k, bus.DIG_IDX, m_idx(k));
      end
      checks++;
      if (bus.SEG_OUT !== m_seg(k)) begin
        errors++; $display("FAIL scan_seg k=%0d got=%h want=%h", k, bus.SEG_OUT, m_seg(k));
      end
      checks++;
      if (zeros4(bus.AN) > 1) begin
        errors++; $display("FAIL scan_onehot k=%0d got=%b want=at most one zero", k, bus.AN);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_blink();
    seg_v[0] = 7'h01; seg_v[1] = 7'h4F; seg_v[2] = 7'h12; seg_v[3] = 7'h06;
    mask_v = 4'b0100;
    hold_reset_release();
    for (int k = 0; k < 16 * PER; k++) begin
      checks++;
      if (bus.SEG_OUT !== m_seg(k)) begin
        errors++; $display("FAIL blink_seg k=%0d got=%h want=%h", k, bus.SEG_OUT, m_seg(k));
      end
      checks++;
      if (bus.AN !== m_an(k)) begin
        errors++; $display("FAIL blink_an k=%0d got=%b want=%b", k, bus.AN, m_an(k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_live_inputs();
    seg_v[0] = 7'h01; seg_v[1] = 7'h4F; seg_v[2] = 7'h12; seg_v[3] = 7'h06;
    mask_v = 4'b0000;
    hold_reset_release();
    for (int k = 0; k < 70; k++) begin
      checks++;
      if (bus.SEG_OUT !== m_seg(k)) begin
        errors++; $display("FAIL live_seg k=%0d got=%h want=%h", k, bus.SEG_OUT, m_seg(k));
      end
      if (k == 4)  seg_v[0] = 7'h7E;
      if (k == 63) mask_v = 4'b0100;
      if (k == 66) mask_v = 4'b0000;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    seg_v[0] = 7'h01; seg_v[1] = 7'h4F; seg_v[2] = 7'h12; seg_v[3] = 7'h06;
    mask_v = 4'b0000;
    hold_reset_release();
    for (int k = 0; k < 25; k++) @(negedge clk);
    checks++;
    if (bus.AN !== 4'b1011) begin
      errors++; $display("FAIL arst_pre_an got=%b want=1011", bus.AN);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.AN !== 4'b1111) begin
      errors++; $display("FAIL arst_an got=%b want=1111", bus.AN);
    end
    checks++;
    if (bus.SEG_OUT !== 7'h7F) begin
      errors++; $display("FAIL arst_seg got=%h want=7f", bus.SEG_OUT);
    end
    checks++;
    if (bus.DIG_IDX !== 2'd3) begin
      errors++; $display("FAIL arst_idx got=%0d want=3", bus.DIG_IDX);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5 * PER; k++) begin
      checks++;
      if (bus.AN !== m_an(k)) begin
        errors++; $display("FAIL arst_seq_an k=%0d got=%b want=%b", k, bus.AN, m_an(k));
      end
      checks++;
      if (bus.DIG_IDX !== m_idx(k)) begin
        errors++; $display("FAIL arst_seq_idx k=%0d got=%0d want=%0d", k, bus.DIG_IDX, m_idx(k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] want;
    seg_v[0] = 7'h01; seg_v[1] = 7'h4F; seg_v[2] = 7'h12; seg_v[3] = 7'h01;
    mask_v = 4'b0000;
`ifdef DISP_SCAN_LZB_EN
    want = 7'h7F;
`else
    want = 7'h01;
`endif
    hold_reset_release();
    for (int k = 0; k < 4 * PER; k++) begin
      if ((k >= 3 * PER + BL) && (k < 4 * PER)) begin
        checks++;
        if (bus.SEG_OUT !== want) begin
          errors++; $display("FAIL lzb_seg k=%0d got=%h want=%h", k, bus.SEG_OUT, want);
        end
        checks++;
        if (bus.AN !== 4'b0111) begin
          errors++; $display("FAIL lzb_an k=%0d got=%b want=0111", k, bus.AN);
        end
      end else if ((k >= BL) && (k < PER)) begin
        checks++;
        if (bus.SEG_OUT !== 7'h01) begin
          errors++; $display("FAIL lzb_dig0 k=%0d got=%h want=01", k, bus.SEG_OUT);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    seg_v[0] = 7'h7F; seg_v[1] = 7'h7F; seg_v[2] = 7'h7F; seg_v[3] = 7'h7F;
    mask_v = 4'b0000;
    test_reset();
    test_scan();
    test_blink();
    test_live_inputs();
    test_async_reset();
    test_leading_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 SHALL have parameter DIV, default 1024, giving the SHOW duration in CLK cycles per digit; legal range 2..65535.
REQ-002 SHALL have parameter BLANK_CYC, default 2, giving the all-off dead time in CLK cycles between digits; legal range 1..255.
REQ-003 SHALL have parameter BLINK_LEN, default 128, giving the blink half-period in completed digit periods; legal range 1..65535.
REQ-004 SHALL have port CLK, input, 1 bit: single system clock, rising-edge.
REQ-005 SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port SEG0, input, 7 bits: unit-seconds segments {A..G}, active-low.
REQ-007 SHALL have port SEG1, input, 7 bits: tens-seconds segments, active-low.
REQ-008 SHALL have port SEG2, input, 7 bits: unit-minutes segments, active-low.
REQ-009 SHALL have port SEG3, input, 7 bits: tens-minutes segments, active-low.
REQ-010 SHALL have port BLINK_MASK, input, 4 bits: bit i=1 makes digit i blink (setting mode).
REQ-011 SHALL have port SEG_OUT, output, 7 bits: shared segment bus {A..G}, active-low, registered.
REQ-012 SHALL have port AN, output, 4 bits: digit enables, one-hot active-low, registered.
REQ-013 SHALL have port DIG_IDX, output, 2 bits: index of the digit currently in SHOW.

Function
REQ-014 SHALL implement two states: BLANK and SHOW.
REQ-015 BLANK SHALL drive AN=4'b1111 and SEG_OUT=7'b1111111 for exactly BLANK_CYC cycles, then increment DIG_IDX modulo 4 (3 wraps to 0) and enter SHOW.
REQ-016 SHOW SHALL last exactly DIV cycles, with AN[DIG_IDX]=0 and the other AN bits at 1, then enter BLANK.
REQ-017 The digit period SHALL be DIV+BLANK_CYC cycles; a full scan SHALL be 4*(DIV+BLANK_CYC) cycles.
REQ-018 In SHOW, SEG_OUT SHALL equal SEGn (n=DIG_IDX) as sampled on the previous rising edge (one-cycle latency); input changes mid-SHOW SHALL propagate.
REQ-019 A blink counter SHALL count completed SHOW periods and toggle blink phase each time BLINK_LEN periods complete, then restart from 0.
REQ-020 When blink phase=1 and BLINK_MASK[DIG_IDX]=1, SEG_OUT SHALL be 7'b1111111 during SHOW while AN behaves normally.
REQ-021 AN SHALL never have more than one bit at 0 on any cycle, including state transitions.
REQ-022 A BLINK_MASK change SHALL take effect on the next cycle; the blink phase SHALL be unaffected by the change.

Reset
REQ-023 On RST_N=0, SHALL asynchronously force: state=BLANK, AN=4'b1111, SEG_OUT=7'b1111111, DIG_IDX=3, all cycle counters=0, blink counter=0, blink phase=0.
REQ-024 After RST_N deasserts, SHALL spend BLANK_CYC cycles in BLANK, then show digit 0 first.
REQ-025 Reset asserted mid-SHOW SHALL blank the display immediately, without waiting for CLK.

Configuration
REQ-026 Macro DISP_SCAN_LZB_EN SHALL enable leading-zero blanking.
REQ-027 With DISP_SCAN_LZB_EN defined, SHOW of digit 3 with SEG3=7'b0000001 (glyph "0") SHALL output SEG_OUT=7'b1111111 while AN[3]=0; all other digits SHALL be unaffected.
REQ-028 With DISP_SCAN_LZB_EN undefined, digit 3 SHALL be displayed verbatim, with no extra logic.

Verification (DIV=8, BLANK_CYC=2, BLINK_LEN=4)
REQ-029 Release reset -> AN=1111 for 2 cycles, then AN=1110 for 8 cycles, then 1111 for 2 cycles, then AN=1101; DIG_IDX sequence 0,1,2,3,0.
REQ-030 SEG0=0x01, SEG1=0x4F, SEG2=0x12, SEG3=0x06 -> SEG_OUT shows each value only while its AN bit is 0, and shows 0x7F in BLANK.
REQ-031 BLINK_MASK=0100 -> digit 2 SEG_OUT=0x7F during SHOW periods 4..7, 12..15, ... and =SEG2 otherwise; the other digits are never blanked.
REQ-032 Assert RST_N low mid-SHOW between clock edges -> AN=1111 and SEG_OUT=0x7F at once; after release, the sequence matches REQ-029.
REQ-033 SEG3=0x01: with DISP_SCAN_LZB_EN, SEG_OUT=0x7F during digit 3 SHOW; without it, SEG_OUT=0x01.
REQ-034 Over 10 full scans, AN is never found with two or more zero bits on any cycle.
